// File: rtl/msg_scroller.sv
// msg_scroller: scrolling 5-bit char-code window with digit scan; define SCROLLER_WRAP_EN for endless looping
module msg_scroller #(
    parameter int MSG_DEPTH = 16,
    parameter int AW        = 4,
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int STEP_DIV  = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [4:0]        wr_data,
    input  logic [AW:0]       msg_len,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic [4:0]        char_code,
    output logic [DIGITS-1:0] digit_sel_n
);
    localparam int SCW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int STW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam int IW  = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [4:0]     mem [MSG_DEPTH];
    logic [SCW-1:0] scan_cnt;
    logic [STW-1:0] step_cnt;
    logic [IW-1:0]  idx;
    logic [AW:0]    pos;
    logic [AW:0]    len;
    logic [AW+1:0]  sum;
    logic [4:0]     win_code;
`ifdef SCROLLER_WRAP_EN
    logic [AW-1:0]  ofs;
`endif

    // message buffer: codes beyond the decoder range are stored as blank
    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data > 5'd17 ? 5'd15 : wr_data;

    // code for the digit currently being scanned; blank when idle or past the message end
    always_comb begin
        sum = (AW+2)'(pos) + (AW+2)'(idx);
`ifdef SCROLLER_WRAP_EN
        ofs = AW'(sum % (AW+2)'(len));
        win_code = state == RUN ? mem[ofs] : 5'd15;
`else
        win_code = (state == RUN && sum < (AW+2)'(len)) ? mem[sum[AW-1:0]] : 5'd15;
`endif
    end

    // digit scan: code and enable registered together so they never disagree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt    <= '0;
            idx         <= '0;
            char_code   <= 5'd15;
            digit_sel_n <= ~DIGITS'(1);
        end else begin
            scan_cnt    <= scan_cnt == SCW'(SCAN_DIV - 1) ? '0 : scan_cnt + SCW'(1);
            if (scan_cnt == SCW'(SCAN_DIV - 1))
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
            char_code   <= win_code;
            digit_sel_n <= ~(DIGITS'(1) << idx);
        end
    end

    // run control: start latches length, step timer advances the window, stop aborts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pos      <= '0;
            len      <= (AW+1)'(1);
            step_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !stop && msg_len != '0 && msg_len <= (AW+1)'(MSG_DEPTH)) begin
                    len      <= msg_len;
                    pos      <= '0;
                    step_cnt <= '0;
                    state    <= RUN;
                    busy     <= 1'b1;
                end
            end else if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (step_cnt == STW'(STEP_DIV - 1)) begin
                step_cnt <= '0;
`ifdef SCROLLER_WRAP_EN
                pos <= pos == len - (AW+1)'(1) ? '0 : pos + (AW+1)'(1);
`else
                if (pos == len) begin
                    done  <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    pos <= pos + (AW+1)'(1);
                end
`endif
            end else begin
                step_cnt <= step_cnt + STW'(1);
            end
        end
    end
endmodule

// File: tb/tb_msg_scroller.sv
// tb_msg_scroller: directed checks of scrolling, scan, stop, ignored starts and async reset
module tb_msg_scroller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [4:0] msg_len = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy;
    logic       done;
    logic [4:0] char_code;
    logic [3:0] digit_sel_n;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] shown [4];
    logic       done_seen = 1'b0;

    msg_scroller #(
        .MSG_DEPTH(16), .AW(4), .DIGITS(4), .SCAN_DIV(2), .STEP_DIV(8)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .start(start), .stop(stop), .busy(busy), .done(done),
        .char_code(char_code), .digit_sel_n(digit_sel_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cap(input int n);
        for (int d = 0; d < 4; d++) shown[d] = 5'd31;
        repeat (n) begin
            @(posedge clk);
            #1;
            done_seen = done_seen | done;
            for (int d = 0; d < 4; d++)
                if (digit_sel_n == ~(4'b0001 << d)) shown[d] = char_code;
        end
    endtask

    task automatic win(input string tag, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input logic [4:0] e);
        check({tag, "_d0"}, 32'(shown[0]), 32'(a));
        check({tag, "_d1"}, 32'(shown[1]), 32'(b));
        check({tag, "_d2"}, 32'(shown[2]), 32'(c));
        check({tag, "_d3"}, 32'(shown[3]), 32'(e));
    endtask

    task automatic wr(input logic [3:0] a, input logic [4:0] dat);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = dat;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] l);
        msg_len = l;
        start = 1'b1;
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_sel", 32'(digit_sel_n), 32'(4'b1110));
        check("rst_code", 32'(char_code), 32'd15);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wr(4'd0, 5'd5);
        wr(4'd1, 5'd2);
        wr(4'd2, 5'd7);
        wr(4'd3, 5'd7);
        wr(4'd4, 5'd12);
        go(5'd5);
        check("run_busy", 32'(busy), 32'd1);
        cap(8);
        win("p0", 5'd5, 5'd2, 5'd7, 5'd7);
        cap(8);
        win("p1", 5'd2, 5'd7, 5'd7, 5'd12);
        cap(16);
`ifdef SCROLLER_WRAP_EN
        cap(8);
        win("wp4", 5'd12, 5'd5, 5'd2, 5'd7);
        cap(8);
        win("wp0", 5'd5, 5'd2, 5'd7, 5'd7);
        check("wrap_nodone", 32'(done_seen), 32'd0);
        check("wrap_busy", 32'(busy), 32'd1);
        halt();
`else
        cap(8);
        win("p4", 5'd12, 5'd15, 5'd15, 5'd15);
        check("p4_nodone", 32'(done_seen), 32'd0);
        check("p4_busy", 32'(busy), 32'd1);
        cap(8);
        win("p5", 5'd15, 5'd15, 5'd15, 5'd15);
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
`endif
        go(5'd5);
        repeat (11) @(posedge clk);
        #1;
        halt();
        check("stop_busy", 32'(busy), 32'd0);
        cap(8);
        win("stop", 5'd15, 5'd15, 5'd15, 5'd15);
        check("stop_nodone", 32'(done_seen), 32'd0);
        msg_len = 5'd5;
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        check("ss_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("ss_idle2", 32'(busy), 32'd0);
        go(5'd0);
        check("len0_ign", 32'(busy), 32'd0);
        go(5'd17);
        check("len17_ign", 32'(busy), 32'd0);
        wr(4'd0, 5'd20);
        go(5'd5);
        wr(4'd1, 5'd16);
        cap(7);
        check("clip_d0", 32'(shown[0]), 32'd15);
        check("live_d1", 32'(shown[1]), 32'd16);
        check("live_d2", 32'(shown[2]), 32'd7);
        halt();
        go(5'd5);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_sel", 32'(digit_sel_n), 32'(4'b1110));
        check("arst_code", 32'(char_code), 32'd15);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
